// File: rtl/down_counter_timer.sv
// Loadable down-counting timer: load a start value, count to zero on enabled clocks, pulse DONE.
// Define DOWNCNT_AUTORELOAD_EN to make the terminal step reload the start value and keep running.
module down_counter_timer #(
   parameter int WIDTH = 3
) (
   input  logic             CK,
   input  logic             RN,
   input  logic             LD_VALID,
   input  logic [WIDTH-1:0] LD_DATA,
   output logic             LD_READY,
   input  logic             EN,
   input  logic             ABORT,
   output logic [WIDTH-1:0] Q,
   output logic             BUSY,
   output logic             DONE,
   output logic             dbg_state
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] q_next;
   logic             done_next;
`ifdef DOWNCNT_AUTORELOAD_EN
   logic [WIDTH-1:0] reload;
   logic [WIDTH-1:0] reload_next;
`endif

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         state  <= IDLE;
         Q      <= '0;
         DONE   <= 1'b0;
`ifdef DOWNCNT_AUTORELOAD_EN
         reload <= '0;
`endif
      end else begin
         state  <= state_next;
         Q      <= q_next;
         DONE   <= done_next;
`ifdef DOWNCNT_AUTORELOAD_EN
         reload <= reload_next;
`endif
      end
   end

   // Handshake: a load transfers on any edge where LD_VALID and LD_READY are both high;
   // LD_READY depends only on registered state, and the producer holds LD_VALID/LD_DATA until then.
   always_comb begin
      state_next  = state;
      q_next      = Q;
      done_next   = 1'b0;
`ifdef DOWNCNT_AUTORELOAD_EN
      reload_next = reload;
`endif
      case (state)
         IDLE: begin
            if (LD_VALID) begin
               q_next = LD_DATA;
`ifdef DOWNCNT_AUTORELOAD_EN
               reload_next = LD_DATA;
`endif
               if (LD_DATA != '0) state_next = RUN;
               else               done_next  = 1'b1;
            end
         end
         RUN: begin
            if (ABORT) begin
               q_next     = '0;
               state_next = IDLE;
            end else if (EN) begin
               if (Q == WIDTH'(1)) begin
                  done_next = 1'b1;
`ifdef DOWNCNT_AUTORELOAD_EN
                  q_next = reload;
`else
                  q_next     = '0;
                  state_next = IDLE;
`endif
               end else begin
                  q_next = Q - WIDTH'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign LD_READY  = (state == IDLE);
   assign BUSY      = (state == RUN);
   assign dbg_state = state;

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: scenario tasks push expected
// {LD_READY,BUSY,DONE,Q} per edge into a queue and pop/compare after each edge.
module tb_down_counter_timer;
   localparam int WIDTH = 3;
   localparam int EW    = WIDTH + 3;

   logic             CK;
   logic             RN;
   logic             LD_VALID;
   logic [WIDTH-1:0] LD_DATA;
   logic             LD_READY;
   logic             EN;
   logic             ABORT;
   logic [WIDTH-1:0] Q;
   logic             BUSY;
   logic             DONE;
   logic             dbg_state;

   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] got;
   logic [EW-1:0] exp;
   int            n_checks;
   int            n_pass;

   down_counter_timer #(.WIDTH(WIDTH)) dut (
      .CK        (CK),
      .RN        (RN),
      .LD_VALID  (LD_VALID),
      .LD_DATA   (LD_DATA),
      .LD_READY  (LD_READY),
      .EN        (EN),
      .ABORT     (ABORT),
      .Q         (Q),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial begin
      CK = 1'b0;
      forever #5 CK = ~CK;
   end

   function automatic logic [EW-1:0] pack(input logic rdy, input logic busy,
                                          input logic done, input int q);
      return {rdy, busy, done, WIDTH'(q)};
   endfunction

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   task automatic test_reset();
      RN = 1'b0;
      #3;
      exp_q.push_back(pack(1, 0, 0, 0));
      got = {LD_READY, BUSY, DONE, Q}; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL reset_initial: got=%b want=%b (ready,busy,done,q)", got, exp);
      else n_pass++;
      RN = 1'b1;
      tick();
      // load 5 and abandon it by asynchronous reset between edges
      LD_VALID = 1'b1; LD_DATA = 3'd5; EN = 1'b1;
      tick();
      LD_VALID = 1'b0;
      exp_q.push_back(pack(0, 1, 0, 5));
      got = {LD_READY, BUSY, DONE, Q}; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL reset_preload: got=%b want=%b (ready,busy,done,q)", got, exp);
      else n_pass++;
      #2 RN = 1'b0;
      #1;
      exp_q.push_back(pack(1, 0, 0, 0));
      got = {LD_READY, BUSY, DONE, Q}; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL reset_async: got=%b want=%b (ready,busy,done,q)", got, exp);
      else n_pass++;
      #1 RN = 1'b1;
      for (int k = 0; k < 2; k++) exp_q.push_back(pack(1, 0, 0, 0));
      for (int k = 0; k < 2; k++) begin
         tick();
         got = {LD_READY, BUSY, DONE, Q}; exp = exp_q.pop_front(); n_checks++;
         if (got !== exp) $display("FAIL reset_hold[%0d]: got=%b want=%b (ready,busy,done,q)", k, got, exp);
         else n_pass++;
      end
      EN = 1'b0;
   endtask

   task automatic test_one_shot(input int v);
      for (int k = 0; k < v; k++) exp_q.push_back(pack(0, 1, 0, v - k));
      exp_q.push_back(pack(1, 0, 1, 0));
      exp_q.push_back(pack(1, 0, 0, 0));
      LD_VALID = 1'b1; LD_DATA = WIDTH'(v); EN = 1'b1;
      tick();
      LD_VALID = 1'b0;
      for (int k = 0; k <= v + 1; k++) begin
         if (k > 0) tick();
         got = {LD_READY, BUSY, DONE, Q}; exp = exp_q.pop_front(); n_checks++;
         if (got !== exp) $display("FAIL one_shot_v%0d[%0d]: got=%b want=%b (ready,busy,done,q)", v, k, got, exp);
         else n_pass++;
      end
      EN = 1'b0;
   endtask

   task automatic test_enable_gating();
      logic [4:0] en_pat;
      en_pat = 5'b10101;
      exp_q.push_back(pack(0, 1, 0, 3));
      exp_q.push_back(pack(0, 1, 0, 2));
      exp_q.push_back(pack(0, 1, 0, 2));
      exp_q.push_back(pack(0, 1, 0, 1));
      exp_q.push_back(pack(0, 1, 0, 1));
      exp_q.push_back(pack(1, 0, 1, 0));
      exp_q.push_back(pack(1, 0, 0, 0));
      LD_VALID = 1'b1; LD_DATA = 3'd3; EN = 1'b0;
      tick();
      LD_VALID = 1'b0;
      for (int k = 0; k < 7; k++) begin
         if (k > 0) begin
            EN = (k <= 5) ? en_pat[k-1] : 1'b0;
            tick();
         end
         got = {LD_READY, BUSY, DONE, Q}; exp = exp_q.pop_front(); n_checks++;
         if (got !== exp) $display("FAIL enable_gating[%0d]: got=%b want=%b (ready,busy,done,q)", k, got, exp);
         else n_pass++;
      end
      EN = 1'b0;
   endtask

   task automatic test_abort();
      for (int k = 0; k < 7; k++) exp_q.push_back(pack(0, 1, 0, 7 - k));
      exp_q.push_back(pack(1, 0, 0, 0));
      exp_q.push_back(pack(1, 0, 0, 0));
      LD_VALID = 1'b1; LD_DATA = 3'd7; EN = 1'b1;
      tick();
      LD_VALID = 1'b0;
      for (int k = 0; k < 9; k++) begin
         if (k > 0) begin
            ABORT = (k == 7);
            tick();
         end
         got = {LD_READY, BUSY, DONE, Q}; exp = exp_q.pop_front(); n_checks++;
         if (got !== exp) $display("FAIL abort[%0d]: got=%b want=%b (ready,busy,done,q)", k, got, exp);
         else n_pass++;
      end
      ABORT = 1'b0; EN = 1'b0;
   endtask

   task automatic test_abort_idle();
      exp_q.push_back(pack(0, 1, 0, 3));
      exp_q.push_back(pack(1, 0, 0, 0));
      LD_VALID = 1'b1; LD_DATA = 3'd3; ABORT = 1'b1; EN = 1'b0;
      tick();
      LD_VALID = 1'b0;
      got = {LD_READY, BUSY, DONE, Q}; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL abort_idle_load: got=%b want=%b (ready,busy,done,q)", got, exp);
      else n_pass++;
      tick();
      got = {LD_READY, BUSY, DONE, Q}; exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) $display("FAIL abort_idle_cancel: got=%b want=%b (ready,busy,done,q)", got, exp);
      else n_pass++;
      ABORT = 1'b0;
   endtask

   task automatic test_load_zero();
      exp_q.push_back(pack(1, 0, 1, 0));
      exp_q.push_back(pack(1, 0, 0, 0));
      LD_VALID = 1'b1; LD_DATA = 3'd0; EN = 1'b1;
      tick();
      LD_VALID = 1'b0;
      for (int k = 0; k < 2; k++) begin
         if (k > 0) tick();
         got = {LD_READY, BUSY, DONE, Q}; exp = exp_q.pop_front(); n_checks++;
         if (got !== exp) $display("FAIL load_zero[%0d]: got=%b want=%b (ready,busy,done,q)", k, got, exp);
         else n_pass++;
      end
      EN = 1'b0;
   endtask

   task automatic test_held_valid();
      exp_q.push_back(pack(0, 1, 0, 2));
      exp_q.push_back(pack(0, 1, 0, 1));
      exp_q.push_back(pack(1, 0, 1, 0));
      exp_q.push_back(pack(0, 1, 0, 4));
      exp_q.push_back(pack(1, 0, 0, 0));
      LD_VALID = 1'b1; LD_DATA = 3'd2; EN = 1'b1;
      tick();
      LD_DATA = 3'd4;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) begin
            if (k == 4) begin LD_VALID = 1'b0; ABORT = 1'b1; end
            tick();
         end
         got = {LD_READY, BUSY, DONE, Q}; exp = exp_q.pop_front(); n_checks++;
         if (got !== exp) $display("FAIL held_valid[%0d]: got=%b want=%b (ready,busy,done,q)", k, got, exp);
         else n_pass++;
      end
      ABORT = 1'b0; EN = 1'b0;
   endtask

   task automatic test_random();
      int v;
      int e;
      int cyc;
      logic en_bit;
      for (int it = 0; it < 8; it++) begin
         v = $urandom_range(1, 7);
         e = 0;
         cyc = 0;
         exp_q.push_back(pack(0, 1, 0, v));
         LD_VALID = 1'b1; LD_DATA = WIDTH'(v); EN = 1'b0;
         tick();
         LD_VALID = 1'b0;
         got = {LD_READY, BUSY, DONE, Q}; exp = exp_q.pop_front(); n_checks++;
         if (got !== exp) $display("FAIL random_load[%0d]: got=%b want=%b (ready,busy,done,q)", it, got, exp);
         else n_pass++;
         while (e < v && cyc < 60) begin
            en_bit = 1'($urandom_range(0, 1));
            EN = en_bit;
            if (en_bit) e++;
            if (e == v) exp_q.push_back(pack(1, 0, 1, 0));
            else        exp_q.push_back(pack(0, 1, 0, v - e));
            tick();
            cyc++;
            got = {LD_READY, BUSY, DONE, Q}; exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) $display("FAIL random_step[%0d.%0d]: got=%b want=%b (ready,busy,done,q)", it, cyc, got, exp);
            else n_pass++;
         end
         if (e < v) begin
            n_checks++;
            $display("FAIL random_budget[%0d]: got=%0d enabled edges want=%0d", it, e, v);
            ABORT = 1'b1; tick(); ABORT = 1'b0;
         end
         EN = 1'b0;
         tick();
      end
   endtask

`ifdef DOWNCNT_AUTORELOAD_EN
   task automatic test_autoreload();
      exp_q.push_back(pack(0, 1, 0, 2));
      exp_q.push_back(pack(0, 1, 0, 1));
      exp_q.push_back(pack(0, 1, 1, 2));
      exp_q.push_back(pack(0, 1, 0, 1));
      exp_q.push_back(pack(0, 1, 1, 2));
      exp_q.push_back(pack(1, 0, 0, 0));
      LD_VALID = 1'b1; LD_DATA = 3'd2; EN = 1'b1;
      tick();
      LD_VALID = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) begin
            ABORT = (k == 5);
            tick();
         end
         got = {LD_READY, BUSY, DONE, Q}; exp = exp_q.pop_front(); n_checks++;
         if (got !== exp) $display("FAIL autoreload_v2[%0d]: got=%b want=%b (ready,busy,done,q)", k, got, exp);
         else n_pass++;
      end
      ABORT = 1'b0;
      exp_q.push_back(pack(0, 1, 0, 1));
      for (int k = 0; k < 3; k++) exp_q.push_back(pack(0, 1, 1, 1));
      exp_q.push_back(pack(1, 0, 0, 0));
      LD_VALID = 1'b1; LD_DATA = 3'd1;
      tick();
      LD_VALID = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) begin
            ABORT = (k == 4);
            tick();
         end
         got = {LD_READY, BUSY, DONE, Q}; exp = exp_q.pop_front(); n_checks++;
         if (got !== exp) $display("FAIL autoreload_v1[%0d]: got=%b want=%b (ready,busy,done,q)", k, got, exp);
         else n_pass++;
      end
      ABORT = 1'b0; EN = 1'b0;
   endtask
`endif

   initial begin
      n_checks = 0;
      n_pass   = 0;
      LD_VALID = 1'b0;
      LD_DATA  = '0;
      EN       = 1'b0;
      ABORT    = 1'b0;
      test_reset();
      test_load_zero();
      test_abort();
      test_abort_idle();
`ifdef DOWNCNT_AUTORELOAD_EN
      test_autoreload();
`else
      test_one_shot(5);
      test_one_shot(7);
      test_enable_gating();
      test_held_valid();
      test_random();
`endif
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got=%0d left want=0", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=simulation still running want=finished");
      $fatal(1, "timeout");
   end

endmodule
